// File: rtl/tx_arb_pkg.sv
// Shared defaults, width helper and arbiter state type for the TX weighted round-robin arbiter.
package tx_arb_pkg;

    localparam int N_SUBAFUS_DEF = 16;
    localparam int WEIGHT_W_DEF  = 4;

    function automatic int logn_of(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int LOGN_SUBAFUS = logn_of(N_SUBAFUS_DEF);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE   = 2'd1,
        BLOCKED = 2'd2
    } t_arb_state;

endpackage

// File: rtl/tx_wrr_arb_rr_pick.sv
// Circular first-set-bit finder: returns the first set bit of vec at or after base, wrapping.
// N must be a power of two so the index addition wraps for free.
module rr_pick #(
    parameter int N    = 16,
    parameter int LOGN = 4
) (
    input  logic [N-1:0]    vec,
    input  logic [LOGN-1:0] base,
    output logic            hit,
    output logic [LOGN-1:0] idx
);

    always_comb begin
        logic [LOGN-1:0] cand;
        hit  = 1'b0;
        idx  = '0;
        cand = '0;
        // Walk from farthest to nearest so the nearest set bit is written last.
        for (int k = N - 1; k >= 0; k--) begin
            cand = base + LOGN'(k);
            if (vec[cand]) begin
                hit = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/tx_wrr_arb.sv
// Weighted round-robin pop arbiter for sub-AFU TX FIFOs with downstream almost-full back-pressure.
// Define TX_WRR_ARB_WEIGHT_EN for per-requester quanta; without it every quantum is 1 (plain round-robin).
module tx_wrr_arb
    import tx_arb_pkg::*;
#(
    parameter int N_SUBAFUS = N_SUBAFUS_DEF,
    parameter int WEIGHT_W  = WEIGHT_W_DEF
) (
    input  logic                            clk,
    input  logic                            resetb,
    input  logic [N_SUBAFUS-1:0]            req,
    input  logic                            out_almFull,
    input  logic [N_SUBAFUS*WEIGHT_W-1:0]   weight_cfg,
    input  logic                            cfg_load,
    output logic [N_SUBAFUS-1:0]            grant,
    output logic [logn_of(N_SUBAFUS)-1:0]   grant_idx,
    output logic                            grant_v
);

    localparam int LOGN = logn_of(N_SUBAFUS);

    t_arb_state             state_q, state_d;
    logic                   owner_q, owner_d;
    logic [LOGN-1:0]        ptr_q, ptr_d;
    logic [WEIGHT_W-1:0]    qleft_q, qleft_d;
    logic [N_SUBAFUS-1:0]   grant_q, grant_d;
    logic [LOGN-1:0]        grant_idx_q, grant_idx_d;
    logic                   grant_v_q, grant_v_d;

    logic [N_SUBAFUS-1:0]   eligible;
    logic [LOGN-1:0]        pick_base;
    logic                   pick_hit;
    logic [LOGN-1:0]        pick_idx;
    logic [WEIGHT_W-1:0]    reload;
    logic                   serving;

    // A requester popped last cycle still shows its old head; skip it once.
    assign eligible  = req & ~grant_q;
    assign pick_base = ptr_q + LOGN'(1);

    rr_pick #(
        .N    (N_SUBAFUS),
        .LOGN (LOGN)
    ) u_rr_pick (
        .vec  (eligible),
        .base (pick_base),
        .hit  (pick_hit),
        .idx  (pick_idx)
    );

`ifdef TX_WRR_ARB_WEIGHT_EN
    logic [N_SUBAFUS*WEIGHT_W-1:0] weight_q, weight_d;
    logic [WEIGHT_W-1:0]           pick_weight;

    assign weight_d    = cfg_load ? weight_cfg : weight_q;
    assign pick_weight = weight_q[pick_idx*WEIGHT_W +: WEIGHT_W];
    // Quantum counts grants after the loading one; a zero weight behaves as one.
    assign reload      = (pick_weight == '0) ? '0 : pick_weight - WEIGHT_W'(1);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            weight_q <= {N_SUBAFUS{WEIGHT_W'(1)}};
        end else begin
            weight_q <= weight_d;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = ^{weight_cfg, cfg_load};
    assign reload     = '0;
`endif

    assign serving = (state_q == SERVE) || ((state_q == BLOCKED) && owner_q);

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        qleft_d     = qleft_q;
        grant_d     = '0;
        grant_idx_d = grant_idx_q;

        if (out_almFull) begin
            state_d = BLOCKED;
            owner_d = serving;
        end else if (serving && (qleft_q != '0) && req[ptr_q]) begin
            state_d = SERVE;
            owner_d = 1'b1;
            // Owner still has quantum; if only pop latency blocks it, wait rather than forfeit.
            if (!grant_q[ptr_q]) begin
                grant_d[ptr_q] = 1'b1;
                grant_idx_d    = ptr_q;
                qleft_d        = qleft_q - WEIGHT_W'(1);
            end
        end else if (pick_hit) begin
            state_d           = SERVE;
            owner_d           = 1'b1;
            grant_d[pick_idx] = 1'b1;
            grant_idx_d       = pick_idx;
            ptr_d             = pick_idx;
            qleft_d           = reload;
        end else begin
            state_d = IDLE;
            owner_d = 1'b0;
        end

        grant_v_d = |grant_d;
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            ptr_q       <= LOGN'(N_SUBAFUS - 1);
            qleft_q     <= '0;
            grant_q     <= '0;
            grant_idx_q <= '0;
            grant_v_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            qleft_q     <= qleft_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            grant_v_q   <= grant_v_d;
        end
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign grant_v   = grant_v_q;

endmodule
